anim_display_ctrl: RTL and testbench



---
 rtl/anim_display_ctrl_pkg.sv | 51 +++++
 rtl/anim_display_ctrl_if.sv | 21 ++
 rtl/anim_display_ctrl_tick_gen.sv | 33 +++
 rtl/anim_display_ctrl.sv | 122 ++++++++++++
 tb/tb_anim_display_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/anim_display_ctrl_pkg.sv
// Shared definitions for the lift 7-segment animation driver.
// Holds the mode encodings, glyph codes, the phase state type and the
// 16-entry active-low segment table (bit order g,f,e,d,c,b,a).
// No ports; imported by anim_display_ctrl.
package anim_pkg;

  typedef enum logic [1:0] {
    MODE_BLANK = 2'd0,
    MODE_UP    = 2'd1,
    MODE_DOWN  = 2'd2,
    MODE_FLOOR = 2'd3
  } mode_e;

  typedef enum logic {
    PHASE_0 = 1'b0,
    PHASE_1 = 1'b1
  } phase_e;

  localparam logic [3:0] GLY_UP_A       = 4'd0;
  localparam logic [3:0] GLY_UP_B       = 4'd1;
  localparam logic [3:0] GLY_DN_A       = 4'd2;
  localparam logic [3:0] GLY_DN_B       = 4'd3;
  localparam logic [3:0] GLY_FLOOR_BASE = 4'd4;
  localparam logic [3:0] GLY_BLANK      = 4'd10;
  localparam logic [3:0] GLY_DASH       = 4'd14;

  // Active-low segments {g,f,e,d,c,b,a}. Codes 4..9 show floor digits 0..5.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h77,  // 0  up A   (d)
    7'h5D,  // 1  up B   (b,f)
    7'h7E,  // 2  down A (a)
    7'h6B,  // 3  down B (c,e)
    7'h40,  // 4  '0'
    7'h79,  // 5  '1'
    7'h24,  // 6  '2'
    7'h30,  // 7  '3'
    7'h19,  // 8  '4'
    7'h12,  // 9  '5'
    7'h7F,  // 10 blank
    7'h7F,  // 11 unused
    7'h7F,  // 12 unused
    7'h7F,  // 13 unused
    7'h3F,  // 14 dash (g)
    7'h7F   // 15 unused
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/anim_display_ctrl_if.sv
// Bus between the lift controller / board pins and anim_display_ctrl.
//   mode       2  display mode (blank, up, down, floor)
//   floor      3  current floor code
//   hold       1  door-open indication
//   seg        7  active-low segments
//   an         NUM_DIGITS active-low anodes
//   frame_tick 1  one-cycle pulse per animation step
// master: controller side; slave: the display driver.
interface anim_display_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic [1:0]            mode;
  logic [2:0]            floor;
  logic                  hold;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_tick;

  modport master (output mode, floor, hold, input seg, an, frame_tick);
  modport slave  (input mode, floor, hold, output seg, an, frame_tick);
endinterface

// File: rtl/anim_display_ctrl_tick_gen.sv
// Clock-enable tick generator.
// Counts 0..DIV-1 and raises tick combinationally on the terminal count,
// i.e. the cycle on which the counter wraps. clr restarts the count and
// suppresses a tick on that cycle.
//   clk   system clock
//   reset synchronous, active-high
//   clr   synchronous restart
//   tick  one-cycle enable every DIV cycles
module tick_gen #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST) && !clr;

  always_ff @(posedge clk) begin
    if (reset || clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/anim_display_ctrl.sv
// Multiplexed common-anode 7-segment animation driver for the lift.
// Single clock; scan and frame rates come from two tick_gen enables.
//   clk    system clock
//   reset  synchronous, active-high
//   bus    anim_display_ctrl_if.slave: mode/floor/hold in,
//          seg/an/frame_tick out (all outputs registered)
// Optional: define ANIM_BLINK_EN to blink digit 0 in floor mode while hold=1.
import anim_pkg::*;

module anim_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned SCAN_HZ    = 400,
  parameter int unsigned FRAME_HZ   = 1,
  parameter int unsigned NUM_FLOORS = 6
) (
  input logic               clk,
  input logic               reset,
  anim_display_ctrl_if.slave bus
);

  localparam int unsigned SCAN_DIV  = CLK_HZ / SCAN_HZ;
  localparam int unsigned FRAME_DIV = CLK_HZ / FRAME_HZ;
  localparam int unsigned IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  mode_e                 mode_in;
  mode_e                 mode_q;
  logic                  mode_chg;
  logic                  scan_tick;
  logic                  frame_tick_w;
  phase_e                phase_q, phase_n;
  logic [IDX_W-1:0]      idx_q, idx_n;
  logic [3:0]            code;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic                  ft_q;

  assign mode_in  = mode_e'(bus.mode);
  assign mode_chg = (mode_in != mode_q);

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  tick_gen #(.DIV(FRAME_DIV)) u_frame (
    .clk   (clk),
    .reset (reset),
    .clr   (mode_chg),
    .tick  (frame_tick_w)
  );

  // mode_q follows the input even in reset, so a mode already applied
  // while reset is held does not count as a change at release.
  always_ff @(posedge clk) begin
    mode_q <= mode_in;
  end

  always_comb begin
    phase_n = phase_q;
    if (mode_chg) begin
      phase_n = PHASE_0;
    end else if (frame_tick_w) begin
      phase_n = (phase_q == PHASE_0) ? PHASE_1 : PHASE_0;
    end

    idx_n = idx_q;
    if (scan_tick) begin
      idx_n = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // idx_q is the slot to be driven at the next scan tick; the glyph
    // uses the post-tick phase so a coincident frame step shows at once.
    code = GLY_BLANK;
    unique case (mode_in)
      MODE_BLANK: code = GLY_BLANK;
      MODE_UP:    code = (idx_q[0] ^ phase_n) ? GLY_UP_B : GLY_UP_A;
      MODE_DOWN:  code = (idx_q[0] ^ phase_n) ? GLY_DN_B : GLY_DN_A;
      MODE_FLOOR: begin
        if (idx_q == '0) begin
          if (32'(bus.floor) >= NUM_FLOORS) begin
            code = GLY_DASH;
          end else begin
            code = GLY_FLOOR_BASE + 4'(bus.floor);
          end
`ifdef ANIM_BLINK_EN
          if (bus.hold && phase_n == PHASE_1) begin
            code = GLY_BLANK;
          end
`endif
        end
      end
      default:    code = GLY_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= PHASE_0;
      idx_q   <= '0;
      seg_q   <= 7'h7F;
      an_q    <= '1;
      ft_q    <= 1'b0;
    end else begin
      phase_q <= phase_n;
      idx_q   <= idx_n;
      ft_q    <= frame_tick_w;
      if (scan_tick) begin
        an_q  <= ~(NUM_DIGITS'(1) << idx_q);
        seg_q <= seg_decode(code);
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = ft_q;

endmodule

// File: tb/tb_anim_display_ctrl.sv
// Self-checking bench for anim_display_ctrl (CLK_HZ=1000, SCAN_HZ=100,
// FRAME_HZ=10, NUM_DIGITS=4). Honours ANIM_BLINK_EN if defined.
module tb_anim_display_ctrl;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  anim_display_ctrl_if #(.NUM_DIGITS(ND)) bus();

  anim_display_ctrl #(
    .NUM_DIGITS (ND),
    .CLK_HZ     (1000),
    .SCAN_HZ    (100),
    .FRAME_HZ   (10),
    .NUM_FLOORS (6)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int code);
    case (code)
      0: return 7'h77;   1: return 7'h5D;   2: return 7'h7E;   3: return 7'h6B;
      4: return 7'h40;   5: return 7'h79;   6: return 7'h24;   7: return 7'h30;
      8: return 7'h19;   9: return 7'h12;  14: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic int ref_code(input int slot, input int mode, input int ph,
                                  input int flr, input bit hold);
    int c;
    case (mode)
      1: c = ((slot + ph) % 2 != 0) ? 1 : 0;
      2: c = ((slot + ph) % 2 != 0) ? 3 : 2;
      3: begin
        if (slot != 0) c = 10;
        else begin
          c = (flr >= 6) ? 14 : 4 + flr;
`ifdef ANIM_BLINK_EN
          if (hold && ph == 1) c = 10;
`endif
        end
      end
      default: c = 10;
    endcase
    return c;
  endfunction

  // Reference model: n = edges since reset release, r = edge of the last
  // animation restart. Frame steps fall every 100 edges after r, scan
  // slots every 10 edges after release.
  int n = 0, r = 0, prev_mode = 0;
  bit model_ok = 1'b0;
  logic [6:0] e_seg;
  logic [3:0] e_an;
  logic       e_ft;

  always @(posedge clk) begin
    int ph, slot;
    if (reset) begin
      n = 0; r = 0;
      e_seg = 7'h7F; e_an = 4'hF; e_ft = 1'b0;
      model_ok = 1'b1;
    end else begin
      n++;
      if (int'(bus.mode) != prev_mode) r = n;
      e_ft = (n > r) && ((n - r) % 100 == 0);
      ph = ((n - r) / 100) % 2;
      if (n % 10 == 0) begin
        slot = (n / 10 - 1) % ND;
        e_an = ~(4'b0001 << slot);
        e_seg = ref_seg(ref_code(slot, int'(bus.mode), ph, int'(bus.floor), bus.hold));
      end
    end
    prev_mode = int'(bus.mode);
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("model_seg", {25'd0, bus.seg}, {25'd0, e_seg});
      check("model_an", {28'd0, bus.an}, {28'd0, e_an});
      check("model_frame_tick", {31'd0, bus.frame_tick}, {31'd0, e_ft});
    end
  end

  int cur = 0;

  task automatic restart(input logic [1:0] m, input logic [2:0] f, input logic h);
    @(negedge clk);
    reset = 1'b1;
    bus.mode = m; bus.floor = f; bus.hold = h;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cur = 0;
  endtask

  task automatic adv(input int target);
    while (cur < target) begin
      @(negedge clk);
      cur++;
    end
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [2:0] floor;
    logic       hold;
    logic [6:0] seg0;
    logic [6:0] seg1;
  } vec_t;

  vec_t tv [8];

  initial begin
    int t1, t2, nt;
    bit t100;
    logic [6:0] blink_exp;

    bus.mode = 2'd0; bus.floor = 3'd0; bus.hold = 1'b0;

    tv[0] = '{2'd0, 3'd0, 1'b0, 7'h7F, 7'h7F};
    tv[1] = '{2'd1, 3'd0, 1'b0, 7'h77, 7'h5D};
    tv[2] = '{2'd2, 3'd0, 1'b0, 7'h7E, 7'h6B};
    tv[3] = '{2'd3, 3'd2, 1'b0, 7'h24, 7'h7F};
    tv[4] = '{2'd3, 3'd7, 1'b0, 7'h3F, 7'h7F};
    tv[5] = '{2'd3, 3'd6, 1'b1, 7'h3F, 7'h7F};
    tv[6] = '{2'd3, 3'd0, 1'b1, 7'h40, 7'h7F};
    tv[7] = '{2'd3, 3'd5, 1'b0, 7'h12, 7'h7F};

    for (int i = 0; i < 8; i++) begin
      restart(tv[i].mode, tv[i].floor, tv[i].hold);
      adv(9);
      check("tv_seg_pre", {25'd0, bus.seg}, 32'h7F);
      check("tv_an_pre", {28'd0, bus.an}, 32'hF);
      adv(10);
      check("tv_an_slot0", {28'd0, bus.an}, 32'hE);
      check("tv_seg_slot0", {25'd0, bus.seg}, {25'd0, tv[i].seg0});
      adv(20);
      check("tv_an_slot1", {28'd0, bus.an}, 32'hD);
      check("tv_seg_slot1", {25'd0, bus.seg}, {25'd0, tv[i].seg1});
    end

    // Scroll up for 200 cycles: anode walk and frame tick placement.
    restart(2'd1, 3'd0, 1'b0);
    t1 = -1; t2 = -1; nt = 0;
    for (int k = 1; k <= 200; k++) begin
      adv(k);
      if (bus.frame_tick) begin
        nt++;
        if (t1 < 0) t1 = k; else t2 = k;
      end
      if (k == 10) check("up_an10", {28'd0, bus.an}, 32'hE);
      if (k == 20) check("up_an20", {28'd0, bus.an}, 32'hD);
      if (k == 30) check("up_an30", {28'd0, bus.an}, 32'hB);
      if (k == 40) check("up_an40", {28'd0, bus.an}, 32'h7);
      if (k == 50) check("up_an50", {28'd0, bus.an}, 32'hE);
      if (k == 10) check("up_d0_before", {25'd0, bus.seg}, 32'h77);
      if (k == 130) check("up_d0_after", {25'd0, bus.seg}, 32'h5D);
    end
    check("up_tick_count", nt, 2);
    check("up_tick_first", t1, 100);
    check("up_tick_second", t2, 200);

    // Mode 1 -> 2 at edge 95 restarts the frame timer.
    restart(2'd1, 3'd0, 1'b0);
    t1 = -1; t100 = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      adv(k);
      if (k == 94) bus.mode = 2'd2;
      if (bus.frame_tick && k == 100) t100 = 1'b1;
      if (bus.frame_tick && t1 < 0) t1 = k;
      if (k == 130) check("chg_d0_glyph", {25'd0, bus.seg}, 32'h7E);
    end
    check("chg_no_tick100", {31'd0, t100}, 32'd0);
    check("chg_tick_first", t1, 195);

    // Floor mode with hold: digit 0 blinks only when blinking is built in.
    restart(2'd3, 3'd0, 1'b1);
    adv(90);
    check("blink_90", {25'd0, bus.seg}, 32'h40);
`ifdef ANIM_BLINK_EN
    blink_exp = 7'h7F;
`else
    blink_exp = 7'h40;
`endif
    adv(130);
    check("blink_130", {25'd0, bus.seg}, {25'd0, blink_exp});
    adv(210);
    check("blink_210", {25'd0, bus.seg}, 32'h40);
    restart(2'd3, 3'd0, 1'b0);
    adv(130);
    check("steady_130", {25'd0, bus.seg}, 32'h40);

    // Reset asserted mid-frame.
    restart(2'd1, 3'd0, 1'b0);
    adv(57);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_seg", {25'd0, bus.seg}, 32'h7F);
    check("midrst_an", {28'd0, bus.an}, 32'hF);
    check("midrst_ft", {31'd0, bus.frame_tick}, 32'd0);
    reset = 1'b0;
    cur = 0;
    adv(9);
    check("midrst_blank_hold", {25'd0, bus.seg}, 32'h7F);

    // Randomised traffic, checked every cycle by the reference model.
    restart(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'b0);
    for (int k = 1; k <= 2500; k++) begin
      adv(k);
      if ($urandom_range(0, 149) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) bus.floor = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) bus.hold = 1'($urandom_range(0, 1));
      if (k == 1234) reset = 1'b1;
      if (k == 1236) reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
